// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the transmit-channel frame arbiter.
package tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_DV = 3'd1,
        PASS    = 3'd2,
        DRAIN   = 3'd3,
        GAP     = 3'd4
    } arb_state_e;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_IFG_CYCLES    = 12;
    localparam int DEF_MAX_LEN       = 1518;
    localparam int DEF_START_TIMEOUT = 16;

    // Never returns 0, so degenerate parameter values still yield a legal vector width.
    function automatic int clog2_safe(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Bundle between the frame sources (master) and the arbiter (slave).
interface tx_frame_arbiter_if
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] rxd;
    logic [NUM_REQ-1:0]   rx_dv;
    logic [NUM_REQ-1:0]   gnt;
    logic [7:0]           txd;
    logic                 tx_en;
    logic                 busy;
    logic [15:0]          frame_cnt;
    logic                 timeout_err;
    logic                 len_err;

    modport master (
        output req,
        output rxd,
        output rx_dv,
        input  gnt,
        input  txd,
        input  tx_en,
        input  busy,
        input  frame_cnt,
        input  timeout_err,
        input  len_err
    );

    modport slave (
        input  req,
        input  rxd,
        input  rx_dv,
        output gnt,
        output txd,
        output tx_en,
        output busy,
        output frame_cnt,
        output timeout_err,
        output len_err
    );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_select
    import tx_arb_pkg::*;
#(
    parameter  int N     = DEF_NUM_REQ,
    localparam int IDX_W = clog2_safe(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    // cand[gi] is the source examined at priority offset gi from the pointer.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = {1'b0, ptr_i} + (IDX_W+1)'(gi);
        assign cand[gi]  = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : sum[IDX_W-1:0];
        assign hit[gi]   = req_i[cand[gi]];
    end

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner_o = cand[i];
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Grants the shared transmit channel to one source per frame, round-robin, with
// inter-frame gap, length cap and start-timeout enforcement.
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
    parameter int MAX_LEN       = DEF_MAX_LEN,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    tx_frame_arbiter_if.slave  bus
);

    localparam int IDX_W = clog2_safe(NUM_REQ);
    localparam int LEN_W = clog2_safe(MAX_LEN + 1);
    localparam int TMO_W = clog2_safe(START_TIMEOUT);
    localparam int GAP_W = clog2_safe(IFG_CYCLES);

    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [NUM_REQ-1:0] GNT_ONE  = NUM_REQ'(1);
    localparam arb_state_e         AFTER_FRAME = (IFG_CYCLES > 0) ? GAP : IDLE;

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [7:0]         txd_q;
    logic               tx_en_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   tmo_d;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_d;
    logic [15:0]        frame_cnt_q;
    logic [15:0]        frame_cnt_d;
    logic               timeout_err_q;
    logic               len_err_q;

    logic [IDX_W-1:0]   rr_winner;
    logic               rr_valid;
    logic [7:0]         rxd_arr [NUM_REQ];
    logic               sel_dv;
    logic               sel_req;
    logic [7:0]         sel_rxd;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign rxd_arr[gi] = bus.rxd[8*gi +: 8];
    end

    // Only the granted source is ever looked at; every other lane is ignored.
    assign sel_dv  = bus.rx_dv[sel_q];
    assign sel_req = bus.req[sel_q];
    assign sel_rxd = rxd_arr[sel_q];

    rr_select #(
        .N (NUM_REQ)
    ) u_rr_select (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (rr_winner),
        .valid_o  (rr_valid)
    );

    assign ptr_d       = (rr_winner == IDX_W'(NUM_REQ - 1)) ? '0 : rr_winner + IDX_W'(1);
    assign len_d       = len_q + LEN_W'(1);
    assign tmo_d       = tmo_q + TMO_W'(1);
    assign gap_d       = gap_q + GAP_W'(1);
    assign frame_cnt_d = frame_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            sel_q         <= '0;
            ptr_q         <= '0;
            txd_q         <= '0;
            tx_en_q       <= 1'b0;
            len_q         <= '0;
            tmo_q         <= '0;
            gap_q         <= '0;
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            len_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rr_valid) begin
                        gnt_q   <= GNT_ONE << rr_winner;
                        sel_q   <= rr_winner;
                        ptr_q   <= ptr_d;
                        tmo_q   <= '0;
                        state_q <= WAIT_DV;
                    end
                end
                WAIT_DV: begin
                    if (sel_dv) begin
                        txd_q   <= sel_rxd;
                        tx_en_q <= 1'b1;
                        len_q   <= LEN_W'(1);
                        state_q <= PASS;
                    end else if (!sel_req) begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        gnt_q         <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                PASS: begin
                    if (sel_dv) begin
                        if (len_q < LEN_MAX) begin
                            txd_q   <= sel_rxd;
                            tx_en_q <= 1'b1;
                            len_q   <= len_d;
                        end else begin
                            // Truncate but keep the grant so the tail of the frame is swallowed.
                            tx_en_q   <= 1'b0;
                            len_err_q <= 1'b1;
                            state_q   <= DRAIN;
                        end
                    end else begin
                        tx_en_q     <= 1'b0;
                        gnt_q       <= '0;
                        frame_cnt_q <= frame_cnt_d;
                        gap_q       <= '0;
                        state_q     <= AFTER_FRAME;
                    end
                end
                DRAIN: begin
                    if (!sel_dv) begin
                        gnt_q       <= '0;
                        frame_cnt_q <= frame_cnt_d;
                        gap_q       <= '0;
                        state_q     <= AFTER_FRAME;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    tx_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.txd         = txd_q;
    assign bus.tx_en       = tx_en_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.len_err     = len_err_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scenario bench for tx_frame_arbiter: forwarded bytes are checked against a scoreboard.
module tb_tx_frame_arbiter;

    localparam int NR  = 4;
    localparam int IFG = 12;
    localparam int ML  = 8;
    localparam int TMO = 16;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    int te_cnt      = 0;
    int le_cnt      = 0;
    int le_cyc      = -1;
    int aa_cnt      = 0;
    int last_en_cyc = -1;
    int min_gap     = 1000;
    int exp_frames  = 0;

    tx_frame_arbiter_if #(.NUM_REQ(NR)) bus ();

    tx_frame_arbiter #(
        .NUM_REQ       (NR),
        .IFG_CYCLES    (IFG),
        .MAX_LEN       (ML),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every tx_en cycle must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.timeout_err === 1'b1) te_cnt++;
            if (bus.len_err === 1'b1) begin
                le_cnt++;
                le_cyc = cyc;
            end
            if (bus.tx_en === 1'b1) begin
                total++;
                if (bus.txd === 8'hAA) aa_cnt++;
                if (last_en_cyc >= 0 && cyc - last_en_cyc > 1 && cyc - last_en_cyc - 1 < min_gap)
                    min_gap = cyc - last_en_cyc - 1;
                last_en_cyc = cyc;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: txd=%h at cyc %0d, required no output", bus.txd, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.txd !== e.data || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL sb_byte: txd=%h cyc=%0d, required txd=%h cyc=%0d",
                                 bus.txd, cyc, e.data, e.cyc);
                    end else begin
                        $display("tx byte %h at cyc %0d", bus.txd, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int limit, output int waited);
        waited = 0;
        while (bus.gnt == '0 && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic drive_frame(input int src, input int n, input logic [7:0] base, input int nfwd);
        for (int k = 0; k < n; k++) begin
            bus.rx_dv[src]       = 1'b1;
            bus.rxd[8*src +: 8]  = 8'(base + 8'(k));
            if (k < nfwd) sb.push_back('{data: 8'(base + 8'(k)), cyc: cyc + 1});
            tick();
        end
        bus.rx_dv[src]      = 1'b0;
        bus.rxd[8*src +: 8] = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: gnt=%b, required 0000", bus.gnt); end
        total++;
        if (bus.txd !== 8'h00 || bus.tx_en !== 1'b0) begin
            bad++; $display("FAIL reset_tx: txd=%h tx_en=%b, required 00 0", bus.txd, bus.tx_en);
        end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: busy=%b, required 0", bus.busy); end
        total++;
        if (bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: frame_cnt=%0d, required 0", bus.frame_cnt); end
        total++;
        if (bus.timeout_err !== 1'b0 || bus.len_err !== 1'b0) begin
            bad++; $display("FAIL reset_err: timeout_err=%b len_err=%b, required 0 0", bus.timeout_err, bus.len_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int w;
        bus.req = 4'b0001;
        tick();
        total++;
        if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: gnt=%b, required 0001", bus.gnt); end
        drive_frame(0, 3, 8'h01, 3);
        tick();
        exp_frames++;
        total++;
        if (bus.frame_cnt !== 16'(exp_frames)) begin
            bad++; $display("FAIL single_cnt: frame_cnt=%0d, required %0d", bus.frame_cnt, exp_frames);
        end
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_end: gnt=%b busy=%b, required 0000 1", bus.gnt, bus.busy);
        end
        wait_gnt(40, w);
        total++;
        if (w != IFG + 1 || bus.gnt !== 4'b0001) begin
            bad++; $display("FAIL single_ifg: regrant after %0d cycles gnt=%b, required %0d 0001", w, bus.gnt, IFG + 1);
        end
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || te_cnt != 0) begin
            bad++; $display("FAIL single_reqdrop: gnt=%b busy=%b timeouts=%0d, required 0000 0 0", bus.gnt, bus.busy, te_cnt);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL single_sb: %0d bytes missing, required 0", sb.size()); end
    endtask

    task automatic test_round_robin();
        int w;
        int src;
        do_reset();
        exp_frames  = 0;
        min_gap     = 1000;
        last_en_cyc = -1;
        bus.req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            src = k % NR;
            wait_gnt(40, w);
            total++;
            if (bus.gnt !== (4'b0001 << src)) begin
                bad++; $display("FAIL rr_order: frame %0d gnt=%b, required %b", k, bus.gnt, 4'b0001 << src);
            end
            drive_frame(src, 4, 8'(16 * (k + 1)), 4);
            if (k == 4) bus.req = 4'b0000;
            tick();
            exp_frames++;
            total++;
            if (bus.frame_cnt !== 16'(exp_frames)) begin
                bad++; $display("FAIL rr_cnt: frame_cnt=%0d, required %0d", bus.frame_cnt, exp_frames);
            end
        end
        total++;
        if (min_gap < IFG) begin bad++; $display("FAIL rr_gap: min idle gap=%0d, required >=%0d", min_gap, IFG); end
    endtask

    task automatic test_timeout();
        int w;
        int te0;
        wait_idle();
        te0     = te_cnt;
        bus.req = 4'b1100;
        tick();
        total++;
        if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL tmo_gnt: gnt=%b, required 0100", bus.gnt); end
        w = 0;
        while (bus.gnt !== 4'b0000 && w < 40) begin
            tick();
            w++;
        end
        total++;
        if (w != TMO || bus.timeout_err !== 1'b1) begin
            bad++; $display("FAIL tmo_revoke: revoked after %0d cycles err=%b, required %0d 1", w, bus.timeout_err, TMO);
        end
        tick();
        total++;
        if (bus.gnt !== 4'b1000 || bus.timeout_err !== 1'b0) begin
            bad++; $display("FAIL tmo_next: gnt=%b err=%b, required 1000 0", bus.gnt, bus.timeout_err);
        end
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || te_cnt - te0 != 1) begin
            bad++; $display("FAIL tmo_pulse: gnt=%b pulses=%0d, required 0000 1", bus.gnt, te_cnt - te0);
        end
    endtask

    task automatic test_len();
        int le0;
        int c0;
        wait_idle();
        le0     = le_cnt;
        bus.req = 4'b0010;
        tick();
        total++;
        if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL len_gnt: gnt=%b, required 0010", bus.gnt); end
        c0 = cyc;
        drive_frame(1, 12, 8'h40, ML);
        total++;
        if (bus.gnt !== 4'b0010 || bus.tx_en !== 1'b0) begin
            bad++; $display("FAIL len_drain: gnt=%b tx_en=%b, required 0010 0", bus.gnt, bus.tx_en);
        end
        bus.req = 4'b0000;
        tick();
        exp_frames++;
        total++;
        if (bus.gnt !== 4'b0000 || bus.frame_cnt !== 16'(exp_frames)) begin
            bad++; $display("FAIL len_end: gnt=%b frame_cnt=%0d, required 0000 %0d", bus.gnt, bus.frame_cnt, exp_frames);
        end
        total++;
        if (le_cnt - le0 != 1 || le_cyc != c0 + ML + 1) begin
            bad++; $display("FAIL len_err: pulses=%0d at cyc %0d, required 1 at %0d", le_cnt - le0, le_cyc, c0 + ML + 1);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL len_sb: %0d bytes missing, required 0", sb.size()); end
    endtask

    task automatic test_isolation();
        int aa0;
        wait_idle();
        aa0              = aa_cnt;
        bus.rx_dv[1]     = 1'b1;
        bus.rxd[15:8]    = 8'hAA;
        bus.req          = 4'b0001;
        tick();
        total++;
        if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL iso_gnt: gnt=%b, required 0001", bus.gnt); end
        drive_frame(0, 5, 8'h20, 5);
        bus.req = 4'b0000;
        tick();
        exp_frames++;
        bus.rx_dv[1]  = 1'b0;
        bus.rxd[15:8] = 8'h00;
        total++;
        if (aa_cnt != aa0 || bus.frame_cnt !== 16'(exp_frames)) begin
            bad++; $display("FAIL iso_leak: AA seen %0d times frame_cnt=%0d, required 0 %0d", aa_cnt - aa0, bus.frame_cnt, exp_frames);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL iso_sb: %0d bytes missing, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        wait_idle();
        bus.req = 4'b0110;
        tick();
        total++;
        if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL rmid_gnt: gnt=%b, required 0010", bus.gnt); end
        for (int k = 0; k < 3; k++) begin
            bus.rx_dv[1]  = 1'b1;
            bus.rxd[15:8] = 8'(8'h60 + 8'(k));
            if (k < 2) sb.push_back('{data: 8'(8'h60 + 8'(k)), cyc: cyc + 1});
            else rst = 1'b1;
            tick();
        end
        total++;
        if (bus.gnt !== 4'b0000 || bus.tx_en !== 1'b0 || bus.txd !== 8'h00 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rmid_out: gnt=%b tx_en=%b txd=%h busy=%b, required 0000 0 00 0",
                            bus.gnt, bus.tx_en, bus.txd, bus.busy);
        end
        total++;
        if (bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt: frame_cnt=%0d, required 0", bus.frame_cnt); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rmid_sb: %0d bytes missing, required 0", sb.size()); end
        rst          = 1'b0;
        bus.rx_dv[1] = 1'b0;
        tick();
        total++;
        if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL rmid_ptr: gnt=%b, required 0010", bus.gnt); end
        bus.req = 4'b0000;
        tick();
    endtask

    initial begin
        bus.req   = '0;
        bus.rx_dv = '0;
        bus.rxd   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_len();
        test_isolation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single byte-wide transmit channel (txd/tx_en) of the loopback DUT between NUM_REQ frame sources.
- Each source requests the channel and is granted it for exactly one frame, in round-robin order.
- The arbiter forwards the granted source's rxd/rx_dv stream to txd/tx_en, enforces a minimum inter-frame gap and a maximum frame length, and revokes grants that are never used.
- It sits between the frame sources and the DUT input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IFG_CYCLES, 12, idle cycles forced on tx_en after every frame (0 allowed)
- MAX_LEN, 1518, maximum bytes forwarded per frame
- START_TIMEOUT, 16, cycles a granted source may wait before raising rx_dv

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-source channel request, level
- rxd  in  NUM_REQ*8  per-source data; source i occupies bits [8i+7:8i]
- rx_dv  in  NUM_REQ  per-source data valid; one frame = one contiguous high run
- gnt  out  NUM_REQ  one-hot grant, registered
- txd  out  8  forwarded data, registered
- tx_en  out  1  forwarded valid, registered
- busy  out  1  high in any state other than IDLE
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0
- timeout_err  out  1  one-cycle pulse on grant revocation
- len_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - On reset: gnt=0, txd=0, tx_en=0, busy=0, frame_cnt=0, timeout_err=0, len_err=0.
  - On reset: state=IDLE and round-robin pointer=0.
  - Reset mid-frame aborts the frame immediately; frame_cnt is not incremented.
- IDLE:
  - If req != 0, select the first set bit scanning from the pointer upward, modulo NUM_REQ.
  - Next cycle: gnt is one-hot for the winner; state=WAIT_DV; the timeout counter clears.
  - The pointer advances to winner+1 at grant time.
- WAIT_DV:
  - If rx_dv[g] is high: enter PASS. That byte is forwarded (txd<=rxd[g], tx_en<=1) and the length count is set to 1.
  - Else if req[g] is low: gnt<=0 and state goes to IDLE, with no error.
  - Else if the counter reaches START_TIMEOUT-1: gnt<=0, timeout_err pulses, state goes to IDLE.
  - Priority of these checks: dv, then req drop, then timeout.
- PASS:
  - While rx_dv[g] is high and len<MAX_LEN: txd<=rxd[g], tx_en<=1, len++.
  - When rx_dv[g] is high and len==MAX_LEN: tx_en<=0, len_err pulses once, state goes to DRAIN.
  - When rx_dv[g] is low: tx_en<=0, gnt<=0, frame_cnt++, then go to GAP (or IDLE if IFG_CYCLES=0).
- DRAIN:
  - tx_en stays 0 until rx_dv[g] falls.
  - Then gnt<=0, frame_cnt++ (a truncated frame still counts), state goes to GAP or IDLE.
- GAP: waits IFG_CYCLES cycles with tx_en=0, then returns to IDLE. Requests are sampled only in IDLE.
- Latency: txd/tx_en lag rxd/rx_dv of the granted source by exactly 1 cycle.
- Non-granted sources: rx_dv/rxd from non-granted sources are ignored in every state.
- Throughput limit: a dv that drops and re-rises within one grant is a new frame. It is not forwarded until that source is granted again.
- Request behaviour: req may drop in PASS without effect. Frame end is defined by dv alone.
- Arithmetic widths:
  - len counter is clog2(MAX_LEN+1) bits.
  - gap and timeout counters are sized to their parameters.
  - frame_cnt wraps modulo 2^16.

Decomposition:
- Package tx_arb_pkg holds:
  - the state enum {IDLE, WAIT_DV, PASS, DRAIN, GAP};
  - the default parameter constants;
  - the function clog2_safe.
- One sub-module, rr_select: combinational round-robin picker.
  - Inputs: req and pointer.
  - Outputs: winner index and a valid flag.
  - It is reused by future schedulers.

Test Plan:
- NUM_REQ=4, req=4'b0001, source 0 sends bytes 01 02 03 -> gnt=0001 one cycle later; txd 01 02 03 with tx_en high, each 1 cycle after the input; then frame_cnt=1 and 12 idle cycles.
- req=4'b1111 held, each source sends a 4-byte frame -> grants in order 0,1,2,3,0; at least 12 cycles of tx_en low between frames.
- req[2]=1 granted, rx_dv[2] never rises -> gnt cleared after 16 cycles, timeout_err pulses once; the next requester (3 if set) is granted next.
- MAX_LEN=8, source 1 sends 12 bytes -> exactly 8 bytes forwarded; len_err pulses on the 9th input byte; gnt is held until dv falls; frame_cnt increments by 1.
- During a frame from source 0, source 1 asserts rx_dv with data AA -> AA never appears on txd.
- rst asserted at the 3rd byte of a frame -> next cycle all outputs 0, state IDLE, frame_cnt=0; a pending req is granted starting from source 0.
